// File: rtl/round_key_sequencer.sv
// round_key_sequencer: streams AES round keys 0..Nr (or Nr..0) from a latched expanded key.
// Optional feature macro: ROUND_REVERSE_EN (enables decrypt-order sequencing).
`default_nettype none

module round_key_sequencer #(
  parameter int KEY_BITS = 1920
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] keyIn,
  input  logic                keyReady,
  input  logic [1:0]          keySize,
  input  logic                go,
  input  logic                decrypt,
  input  logic                rkReady,
  output logic [127:0]        rkOut,
  output logic                rkValid,
  output logic [3:0]          rkIndex,
  output logic                rkLast,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state;
  logic [KEY_BITS-1:0] key_reg;
  logic                key_loaded;
  logic                pending;
  logic                ready_q;
  logic                armed;
  logic                reverse;
  logic [3:0]          last_idx;

  logic                key_rise;
  logic                capture;
  logic                rev_sel;
  logic [3:0]          nr_sel;
  logic [3:0]          first_idx;
  logic [3:0]          next_idx;
  logic [KEY_BITS-1:0] key_src;

  // armed stays low until keyReady is seen low, so a level already high out of reset is not an edge
  assign key_rise = keyReady & ~ready_q & armed;
  assign capture  = pending | key_rise;
  assign key_src  = capture ? keyIn : key_reg;

  always_comb begin
    nr_sel = 4'd14;
    case (keySize)
      2'd0:    nr_sel = 4'd10;
      2'd1:    nr_sel = 4'd12;
      default: nr_sel = 4'd14;
    endcase
  end

`ifdef ROUND_REVERSE_EN
  assign rev_sel = decrypt;
`else
  assign rev_sel = decrypt & 1'b0;
`endif

  assign first_idx = rev_sel ? nr_sel : 4'd0;
  assign next_idx  = reverse ? (rkIndex - 4'd1) : (rkIndex + 4'd1);

  function automatic logic [127:0] round_key(input logic [KEY_BITS-1:0] k, input logic [3:0] r);
    return k[KEY_BITS - 1 - 128 * int'(r) -: 128];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      key_reg    <= '0;
      key_loaded <= 1'b0;
      pending    <= 1'b0;
      ready_q    <= 1'b0;
      armed      <= 1'b0;
      reverse    <= 1'b0;
      last_idx   <= 4'd0;
      rkOut      <= '0;
      rkValid    <= 1'b0;
      rkIndex    <= 4'd0;
      rkLast     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ready_q <= keyReady;
      armed   <= armed | ~keyReady;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            key_reg    <= keyIn;
            key_loaded <= 1'b1;
            pending    <= 1'b0;
          end
          if (go) begin
            if (key_loaded) begin
              state    <= STREAM;
              rkValid  <= 1'b1;
              busy     <= 1'b1;
              reverse  <= rev_sel;
              last_idx <= rev_sel ? 4'd0 : nr_sel;
              rkIndex  <= first_idx;
              rkOut    <= round_key(key_src, first_idx);
              rkLast   <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        STREAM: begin
          // a new key must not disturb the sequence in flight; it is taken once back in IDLE
          if (key_rise) pending <= 1'b1;
          if (rkValid && rkReady) begin
            if (rkLast) begin
              state   <= IDLE;
              rkValid <= 1'b0;
              busy    <= 1'b0;
              rkLast  <= 1'b0;
              done    <= 1'b1;
            end else begin
              rkIndex <= next_idx;
              rkOut   <= round_key(key_reg, next_idx);
              rkLast  <= (next_idx == last_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as listed below.
REQ-002 The block SHALL have one parameter: KEY_BITS, default 1920, the width of the expanded-key input (60 x 32-bit words); only 1920 is supported.
REQ-003 The ports SHALL be:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- keyIn  input  KEY_BITS  expanded key from the key buffer; word 0 is in bits [1919:1888].
- keyReady  input  1  key buffer output valid; level signal.
- keySize  input  2  key size: 0 = 128, 1 = 192, 2 = 256, 3 = treated as 256.
- go  input  1  start-sequence request; one-cycle pulse.
- decrypt  input  1  requests reverse key order.
- rkReady  input  1  consumer ready.
- rkOut  output  128  current round key.
- rkValid  output  1  rkOut is valid.
- rkIndex  output  4  round number of rkOut.
- rkLast  output  1  rkOut is the final key of the sequence.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse after the final transfer.
- err  output  1  one-cycle pulse when go arrives with no key loaded.

Function
REQ-004 Key latch: on a keyReady rising edge (registered edge detect) in IDLE, the block SHALL copy keyIn to an internal key register and set keyLoaded.
REQ-005 A keyReady rising edge during STREAM SHALL set a pending flag instead of latching; in the first IDLE cycle the block SHALL capture the then-current keyIn and clear the flag.
REQ-006 Round key r SHALL be taken from internal key bits [1919-128r -: 128], i.e. words 4r..4r+3.
REQ-007 Nr SHALL be 10, 12 or 14 for keySize 0, 1 and 2/3; keySize SHALL be sampled when go is accepted.
REQ-008 The FSM SHALL have states IDLE and STREAM.
REQ-009 IDLE -> STREAM on go=1 with keyLoaded=1; rkValid and busy SHALL be high in the next cycle.
REQ-010 In IDLE, go=1 with keyLoaded=0 SHALL pulse err for exactly one cycle and remain in IDLE.
REQ-011 go during STREAM SHALL be ignored, with no err.
REQ-012 Forward order: rkIndex SHALL run 0..Nr. Reverse order: rkIndex SHALL run Nr..0.
REQ-013 A transfer SHALL occur when rkValid and rkReady are both 1; the index advances on the next edge.
REQ-014 rkOut, rkIndex and rkLast SHALL stay stable while rkValid=1 and rkReady=0.
REQ-015 With rkReady held high, the block SHALL transfer one key per cycle with no bubbles.
REQ-016 rkLast SHALL be 1 only while the final key (index Nr forward, index 0 reverse) is presented.
REQ-017 On the final transfer, the next cycle SHALL have rkValid=0, busy=0 and done=1 for one cycle, with the FSM back in IDLE.
REQ-018 keyLoaded SHALL persist across sequences; a new go after done restarts the sequence with the same key.
REQ-019 Unused upper round keys (r > Nr) SHALL never be emitted.

Reset
REQ-020 Asserting reset SHALL, at any time including mid-STREAM, force IDLE, rkOut=0, rkValid=0, rkIndex=0, rkLast=0, busy=0, done=0, err=0, keyLoaded=0, pending=0 and clear the edge-detect register.
REQ-021 If keyReady is already high when reset deasserts, it SHALL NOT count as a rising edge; the key buffer must re-pulse it.

Configuration
REQ-022 Macro ROUND_REVERSE_EN: when defined, decrypt is sampled at go acceptance and decrypt=1 selects reverse order.
REQ-023 When ROUND_REVERSE_EN is undefined, the decrypt port SHALL remain present but be ignored, and order SHALL always be forward.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load keyIn with word n = n, keySize=2, go, rkReady=1 -> 15 transfers over 15 consecutive cycles; key 0 = {0,1,2,3}; key 14 = {56,57,58,59} with rkLast=1; done on cycle 16.
- keySize=0, rkReady toggling 1/0 -> exactly 11 keys, index 0..10; rkOut held stable during rkReady=0 cycles; rkLast only with index 10.
- ROUND_REVERSE_EN defined, decrypt=1, keySize=1 -> indices 12..0; first key = words 48..51; rkLast with index 0. Same stimulus with the macro undefined -> indices 0..12.
- go after reset with no keyReady edge -> err=1 for one cycle, rkValid stays 0, busy stays 0.
- reset asserted at index 5 of STREAM -> all outputs 0 immediately; a following go gives an err pulse because keyLoaded was cleared.
- New keyReady edge during STREAM -> the current sequence finishes with the old key; the next sequence uses the new key.
